clkdiv_bank: RTL and testbench
==============================

# clkdiv_bank

Multi-channel programmable clock divider for the lab-board designs. It replaces single-output, fixed-mode dividers. Each of `CH` channels divides the system clock by a runtime-programmable value and produces two outputs: a 50 % square wave for driving slow logic or LEDs, and a one-cycle tick suited for use as a clock enable. Divisor updates are glitch-free, and a common sync input phase-aligns all channels, for example keypad scan, display refresh and blink timers in the lock controller.

## Interface
Parameters:
- `CH`, default 4: number of independent channels (1..16).
- `W`, default 32: counter and divisor width per channel (2..32).

Ports:
- `clk`  in  1: system clock; everything is on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `en`  in  CH: per-channel enable; low means the channel is held idle.
- `div`  in  CH*W: per-channel half-period terminal count; channel i uses `div[i*W +: W]`.
- `load`  in  CH: per-channel strobe that captures `div` slice i into the shadow register.
- `sync`  in  1: one-cycle pulse that restarts all enabled channels in phase.
- `sq`  out  CH: registered square-wave output per channel.
- `tick`  out  CH: registered one-cycle pulse per channel at each terminal count.

## Operation
- **Per-channel state:** `cnt` (W bits), `div_sh` (shadow), `div_act` (active terminal count), `sq`, `tick`.
- **Reset** (`rst_n` low at an edge): all `cnt`, `div_sh`, `div_act`, `sq` and `tick` are 0.
- **Load:** `load[i]` high captures `div` slice i into `div_sh[i]` at that edge. The captured value becomes active as follows:
  - Channel enabled: `div_act` takes `div_sh` at the next terminal count, or at the next `sync`.
  - `en[i]` low, or at the cycle `en[i]` rises: `div_act` takes `div_sh` immediately.
  - Load on the same edge as a terminal count: the compare uses the old `div_act`, and the new value is in force from the following period.
- **Counting** (`en[i]` high, no `sync`):
  - If `cnt == div_act`: `cnt` goes to 0, `tick` goes to 1, `sq` toggles, and `div_act` takes `div_sh`.
  - Otherwise: `cnt` increments and `tick` goes to 0.
- **Periods:**
  - `sq` period is 2·(div_act+1) clocks, duty exactly 50 %.
  - `tick` period is div_act+1 clocks. Each tick is 1 clock wide, except when div_act=0, where `tick` stays high continuously.
- **Disabled** (`en[i]` low): `cnt`, `sq` and `tick` are forced to 0 at each edge, and the shadow value passes through to `div_act`.
- **Sync** (`sync` high, channel enabled): `cnt`, `sq` and `tick` go to 0, and `div_act` takes `div_sh`.
  - `sync` overrides a coincident terminal count.
  - `sync` has no effect on disabled channels.
- **Priority per edge:** `rst_n` > `en` low > `sync` > terminal count > increment.
- **Wrap:** `cnt` never exceeds `div_act`. A `div_act` of all ones is legal and gives the maximum period, with no overflow.
- **Independence:** channels never interact except through the shared `sync`.

## Timing
- All outputs are registered, and no output has a combinational path from any input.
- **First tick:** with `en[i]` first sampled high at edge k and `div_act`=D, the first `tick` is high after edge k+D, i.e. D+1 enabled edges. `sq` rises at that same edge.
- **Load latency:** a `load` while disabled is effective for the first period after enable. A `load` while running takes effect at most D+1 clocks later, at a period boundary, so no runt or stretched half-period ever appears on `sq`.
- **After `sync` at edge s:** the first `tick` and `sq` rise on each enabled channel is at edge s+D_i+1. Channels with equal D tick on the same edge.
- **Reset mid-operation:** outputs are 0 after the reset edge. The first tick then needs a `load` (div_act=0 after reset gives a continuous tick once enabled).

## Test plan
- **Basic division:** reset, then `load`=1 with div=3 on ch0 while disabled, then `en[0]`=1 → `tick` every 4 clocks, `sq` toggles every 4 clocks (period 8, 4 high/4 low), first tick 4 edges after enable.
- **Zero divisor:** div=0 on ch1 → `sq` toggles every clock, `tick` stays high, `cnt` stays 0.
- **Live reload:** ch0 running at div=5; pulse `load` with div=1 mid-period → the current half-period completes at 6 clocks, then half-periods are 2 clocks. No half-period other than 6 or 2 is ever observed.
- **Sync alignment:** ch0 div=2, ch1 div=2, enabled 1 clock apart, then `sync` → `tick[0]` and `tick[1]` coincide 3 edges after sync. Also assert sync on a terminal-count edge → no tick on that edge.
- **Disable/reset mid-run:** drop `en[2]` → `sq[2]` and `tick[2]` are 0 next edge, and the other channels are unaffected. Drop `rst_n` for 1 clock mid-count → all outputs 0, and `div_act` is 0.
- **Max width:** W=8, div=255 → `tick` period 256, `sq` period 512, no wrap glitch.

Source files
------------

// File: rtl/clkdiv_bank.sv
// clkdiv_bank: CH independent programmable clock dividers, each producing a
// 50% square wave (sq) and a one-cycle terminal-count pulse (tick). Divisors
// are written to a shadow register and become active only at a period
// boundary, at sync, or while the channel is idle, so sq never shows a runt.
module clkdiv_bank #(
    parameter int unsigned CH = 4,
    parameter int unsigned W  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   en,
    input  logic [CH*W-1:0] div,
    input  logic [CH-1:0]   load,
    input  logic            sync,
    output logic [CH-1:0]   sq,
    output logic [CH-1:0]   tick
);

    logic [W-1:0] cnt     [CH];
    logic [W-1:0] div_sh  [CH];
    logic [W-1:0] div_act [CH];
    logic [W-1:0] sh_next [CH];

    // Shadow value as it stands after this edge; a load coinciding with a
    // period boundary is forwarded so it governs the period that starts there.
    always_comb begin
        for (int unsigned i = 0; i < CH; i++) begin
            sh_next[i] = load[i] ? div[i*W +: W] : div_sh[i];
        end
    end

    // Per-channel counter, divisor hand-over and registered outputs.
    // While idle, div_act tracks the shadow every edge, so the first enabled
    // edge already compares against the freshest programmed value.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < CH; i++) begin
            if (!rst_n) begin
                cnt[i]     <= '0;
                div_sh[i]  <= '0;
                div_act[i] <= '0;
                sq[i]      <= 1'b0;
                tick[i]    <= 1'b0;
            end else begin
                div_sh[i] <= sh_next[i];
                if (!en[i] || sync) begin
                    cnt[i]     <= '0;
                    sq[i]      <= 1'b0;
                    tick[i]    <= 1'b0;
                    div_act[i] <= sh_next[i];
                end else if (cnt[i] == div_act[i]) begin
                    cnt[i]     <= '0;
                    tick[i]    <= 1'b1;
                    sq[i]      <= ~sq[i];
                    div_act[i] <= sh_next[i];
                end else begin
                    cnt[i]  <= cnt[i] + W'(1);
                    tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Directed testbench for clkdiv_bank (4 channels, 8-bit divisors).
module tb_clkdiv_bank;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 8;

    logic            clk;
    logic            rst_n;
    logic [CH-1:0]   en;
    logic [CH*W-1:0] div;
    logic [CH-1:0]   load;
    logic            sync;
    logic [CH-1:0]   sq;
    logic [CH-1:0]   tick;

    int n_cmp;
    int n_err;

    clkdiv_bank #(.CH(CH), .W(W)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .div  (div),
        .load (load),
        .sync (sync),
        .sq   (sq),
        .tick (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge and settle just after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 4'hF;
        load  = 4'hF;
        div   = 32'hFFFF_FFFF;
        sync  = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if (sq !== 4'h0) begin
            n_err++;
            $display("FAIL reset_sq got=%b exp=%b", sq, 4'h0);
        end
        n_cmp++;
        if (tick !== 4'h0) begin
            n_err++;
            $display("FAIL reset_tick got=%b exp=%b", tick, 4'h0);
        end
        en    = 4'h0;
        load  = 4'h0;
        div   = '0;
        rst_n = 1'b1;
        cyc();
        cyc();
    endtask

    // div=3 loaded while idle: tick every 4, sq 4 high / 4 low, first tick at k+3
    task automatic test_basic();
        logic et, es;
        div[0*W +: W] = 8'd3;
        load = 4'b0001;
        cyc();
        load = 4'b0000;
        en   = 4'b0001;
        for (int j = 0; j < 16; j++) begin
            cyc();
            et = (j % 4) == 3;
            es = (((j + 1) / 4) % 2) == 1;
            n_cmp++;
            if (tick[0] !== et) begin
                n_err++;
                $display("FAIL basic_tick j=%0d got=%b exp=%b", j, tick[0], et);
            end
            n_cmp++;
            if (sq[0] !== es) begin
                n_err++;
                $display("FAIL basic_sq j=%0d got=%b exp=%b", j, sq[0], es);
            end
        end
        en = 4'b0000;
        cyc();
    endtask

    // div=0: tick continuously high, sq toggles every clock
    task automatic test_zero();
        logic es;
        div[1*W +: W] = 8'd0;
        load = 4'b0010;
        cyc();
        load = 4'b0000;
        en   = 4'b0010;
        for (int j = 0; j < 6; j++) begin
            cyc();
            es = (j % 2) == 0;
            n_cmp++;
            if (tick[1] !== 1'b1) begin
                n_err++;
                $display("FAIL zero_tick j=%0d got=%b exp=%b", j, tick[1], 1'b1);
            end
            n_cmp++;
            if (sq[1] !== es) begin
                n_err++;
                $display("FAIL zero_sq j=%0d got=%b exp=%b", j, sq[1], es);
            end
        end
        en = 4'b0000;
        cyc();
    endtask

    // div=5 running, reload with 1 at edge 8: toggles at 5, 11, 13, 15, ...
    task automatic test_live_reload();
        logic et, es, prev;
        int   last;
        int   hp;
        div[0*W +: W] = 8'd5;
        load = 4'b0001;
        cyc();
        load = 4'b0000;
        en   = 4'b0001;
        prev = 1'b0;
        last = -1;
        for (int j = 0; j < 24; j++) begin
            cyc();
            if (j < 5) begin
                es = 1'b0;
                et = 1'b0;
            end else if (j < 11) begin
                es = 1'b1;
                et = (j == 5);
            end else begin
                es = (((j - 11) / 2) % 2) == 1;
                et = ((j - 11) % 2) == 0;
            end
            n_cmp++;
            if (tick[0] !== et) begin
                n_err++;
                $display("FAIL reload_tick j=%0d got=%b exp=%b", j, tick[0], et);
            end
            n_cmp++;
            if (sq[0] !== es) begin
                n_err++;
                $display("FAIL reload_sq j=%0d got=%b exp=%b", j, sq[0], es);
            end
            if (sq[0] !== prev) begin
                if (last >= 0) begin
                    hp = j - last;
                    n_cmp++;
                    if (hp != 6 && hp != 2) begin
                        n_err++;
                        $display("FAIL reload_halfperiod j=%0d got=%0d exp=6or2", j, hp);
                    end
                end
                last = j;
            end
            prev = sq[0];
            load = (j == 7) ? 4'b0001 : 4'b0000;
            if (j == 7) div[0*W +: W] = 8'd1;
        end
        load = 4'b0000;
        en   = 4'b0000;
        cyc();
    endtask

    // ch0/ch1 div=2 enabled one clock apart, realigned by sync; sync on a TC edge
    task automatic test_sync();
        logic [1:0] et, es;
        div[0*W +: W] = 8'd2;
        div[1*W +: W] = 8'd2;
        load = 4'b0011;
        cyc();
        load = 4'b0000;
        en   = 4'b0001;
        cyc();
        en   = 4'b0011;
        cyc();
        cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        n_cmp++;
        if ({tick[1:0], sq[1:0]} !== 4'b0000) begin
            n_err++;
            $display("FAIL sync_edge got=%b exp=%b", {tick[1:0], sq[1:0]}, 4'b0000);
        end
        for (int j = 1; j <= 5; j++) begin
            cyc();
            et = ((j % 3) == 0) ? 2'b11 : 2'b00;
            es = (j >= 3) ? 2'b11 : 2'b00;
            n_cmp++;
            if (tick[1:0] !== et) begin
                n_err++;
                $display("FAIL sync_tick j=%0d got=%b exp=%b", j, tick[1:0], et);
            end
            n_cmp++;
            if (sq[1:0] !== es) begin
                n_err++;
                $display("FAIL sync_sq j=%0d got=%b exp=%b", j, sq[1:0], es);
            end
        end
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        n_cmp++;
        if ({tick[1:0], sq[1:0]} !== 4'b0000) begin
            n_err++;
            $display("FAIL sync_over_tc got=%b exp=%b", {tick[1:0], sq[1:0]}, 4'b0000);
        end
        cyc();
        cyc();
        cyc();
        n_cmp++;
        if ({tick[1:0], sq[1:0]} !== 4'b1111) begin
            n_err++;
            $display("FAIL sync_after_tc got=%b exp=%b", {tick[1:0], sq[1:0]}, 4'b1111);
        end
        en = 4'b0000;
        cyc();
    endtask

    // drop en[2] mid-run, then a one-clock reset mid-count
    task automatic test_disable_reset();
        div[2*W +: W] = 8'd1;
        load = 4'b0100;
        cyc();
        load = 4'b0000;
        en   = 4'b0111;
        for (int j = 0; j < 5; j++) cyc();
        en = 4'b0011;
        cyc();
        n_cmp++;
        if ({tick[2], sq[2]} !== 2'b00) begin
            n_err++;
            $display("FAIL dis_ch2 got=%b exp=%b", {tick[2], sq[2]}, 2'b00);
        end
        n_cmp++;
        if ({tick[1:0], sq[1:0]} !== 4'b1100) begin
            n_err++;
            $display("FAIL dis_others got=%b exp=%b", {tick[1:0], sq[1:0]}, 4'b1100);
        end
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        n_cmp++;
        if ({tick, sq} !== 8'h00) begin
            n_err++;
            $display("FAIL midrst_out got=%b exp=%b", {tick, sq}, 8'h00);
        end
        for (int j = 0; j < 3; j++) begin
            cyc();
            n_cmp++;
            if (tick[1:0] !== 2'b11) begin
                n_err++;
                $display("FAIL midrst_tick j=%0d got=%b exp=%b", j, tick[1:0], 2'b11);
            end
            n_cmp++;
            if (sq[1:0] !== (((j % 2) == 0) ? 2'b11 : 2'b00)) begin
                n_err++;
                $display("FAIL midrst_sq j=%0d got=%b exp=%b", j, sq[1:0],
                         (((j % 2) == 0) ? 2'b11 : 2'b00));
            end
        end
        en = 4'b0000;
        cyc();
    endtask

    // div=255 on an 8-bit channel: tick period 256, sq period 512
    task automatic test_max();
        logic et, es;
        div[3*W +: W] = 8'd255;
        load = 4'b1000;
        cyc();
        load = 4'b0000;
        en   = 4'b1000;
        for (int j = 0; j < 1100; j++) begin
            cyc();
            et = (j % 256) == 255;
            es = (((j + 1) / 256) % 2) == 1;
            n_cmp++;
            if (tick[3] !== et) begin
                n_err++;
                $display("FAIL max_tick j=%0d got=%b exp=%b", j, tick[3], et);
            end
            n_cmp++;
            if (sq[3] !== es) begin
                n_err++;
                $display("FAIL max_sq j=%0d got=%b exp=%b", j, sq[3], es);
            end
        end
        en = 4'b0000;
        cyc();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = '0;
        div   = '0;
        load  = '0;
        sync  = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_live_reload();
        test_sync();
        test_disable_reset();
        test_max();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
